barrett_param_gen: RTL and testbench

Sequential precompute engine that generates the Barrett constants the modular-reduction datapath consumes. Given a modulus `m`, it produces `md = floor(2^k / m)`, the shift amounts `k`, `k_shft_ah` and `k_shft_ahxmd`, and `mx3`. It sits on the configuration side of each reducer instance, between the modulus register file and the reducer's constant inputs. Moduli outside the NTT-friendly form are rejected.

---
 rtl/barrett_pkg.sv | 29 ++
 rtl/bit_len_enc.sv | 17 +
 rtl/barrett_param_gen.sv | 134 +++++++++++++
 tb/tb_barrett_param_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/barrett_pkg.sv
// Shared types and width helpers for the Barrett constant generator and the
// reducer constant ports that consume its outputs.
package barrett_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LEN  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int NBITS_DEF = 128;
  localparam int KW = $clog2(NBITS_DEF) + 2;
  localparam int SW = $clog2(NBITS_DEF) + 1;

  function automatic int kw_of(input int nbits);
    return $clog2(nbits) + 2;
  endfunction

  function automatic int sw_of(input int nbits);
    return $clog2(nbits) + 1;
  endfunction

  // Bits of m that must read as ...0001 for an NTT-friendly modulus.
  function automatic logic [1023:0] low_mask(input int l2pd);
    return (1024'(1) << (l2pd + 1)) - 1024'(1);
  endfunction

endpackage

// File: rtl/bit_len_enc.sv
// Combinational priority encoder: bit length (MSB index + 1) of the input,
// 0 for an all-zero input.
module bit_len_enc #(
  parameter int W  = 128,
  parameter int OW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_i,
  output logic [OW-1:0] n_o
);

  always_comb begin
    n_o = '0;
    for (int i = 0; i < W; i++)
      if (in_i[i]) n_o = OW'(i + 1);
  end

endmodule

// File: rtl/barrett_param_gen.sv
// Sequential Barrett constant generator: bit length, shift amounts, 3m, and
// md = floor(2^(2n)/m) by restoring division, one quotient bit per cycle.
module barrett_param_gen
  import barrett_pkg::*;
#(
  parameter int NBITS       = 128,
  parameter int LOG2POLYDEG = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NBITS-1:0]          m,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [NBITS:0]            md,
  output logic [kw_of(NBITS)-1:0]   k,
  output logic [sw_of(NBITS)-1:0]   k_shft_ah,
  output logic [sw_of(NBITS)-1:0]   k_shft_ahxmd,
  output logic [NBITS+1:0]          mx3
);

  localparam int KWL = kw_of(NBITS);
  localparam int SWL = sw_of(NBITS);
  localparam logic [NBITS-1:0] LOW_MASK = NBITS'(low_mask(LOG2POLYDEG));

  state_e            state_q, state_d;
  logic [NBITS-1:0]  m_q;
  logic [NBITS:0]    r_q, q_q, md_q;
  logic [KWL-1:0]    cnt_q, k_int_q, k_q;
  logic [SWL-1:0]    ksa_int_q, ksx_int_q, ksa_q, ksx_q;
  logic [NBITS+1:0]  mx3_int_q, mx3_q;
  logic              err_q;

  logic              m_valid;
  logic [KWL-1:0]    n;
  logic [NBITS:0]    r2, r_nxt, q_nxt;
  logic              ge;

  assign m_valid = ((m & LOW_MASK) == NBITS'(1)) && ((m & ~LOW_MASK) != '0);

  bit_len_enc #(.W(NBITS), .OW(KWL)) u_enc (
    .in_i (m_q),
    .n_o  (n)
  );

  // r < m always holds, so the doubled remainder fits in NBITS+1 bits.
  assign r2    = {r_q[NBITS-1:0], 1'b0};
  assign ge    = r2 >= {1'b0, m_q};
  assign r_nxt = ge ? r2 - {1'b0, m_q} : r2;
  assign q_nxt = {q_q[NBITS-1:0], ge};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = m_valid ? S_LEN : S_DONE;
      S_LEN:  state_d = S_DIV;
      S_DIV:  if (cnt_q == KWL'(1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      k_int_q   <= '0;
      ksa_int_q <= '0;
      ksx_int_q <= '0;
      mx3_int_q <= '0;
      md_q      <= '0;
      k_q       <= '0;
      ksa_q     <= '0;
      ksx_q     <= '0;
      mx3_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (start) begin
          if (m_valid) begin
            m_q <= m;
          end else begin
            err_q <= 1'b1;
            md_q  <= '0;
            k_q   <= '0;
            ksa_q <= '0;
            ksx_q <= '0;
            mx3_q <= '0;
          end
        end
        S_LEN: begin
          k_int_q   <= {n[KWL-2:0], 1'b0};
          ksa_int_q <= SWL'(n - KWL'(1));
          ksx_int_q <= SWL'(n + KWL'(1));
          mx3_int_q <= ({2'b00, m_q} << 1) + {2'b00, m_q};
          r_q       <= (NBITS+1)'(1) << (n - KWL'(1));
          q_q       <= '0;
          cnt_q     <= n + KWL'(1);
        end
        S_DIV: begin
          r_q   <= r_nxt;
          q_q   <= q_nxt;
          cnt_q <= cnt_q - KWL'(1);
          // Publish on the final step so every output is valid alongside done.
          if (cnt_q == KWL'(1)) begin
            md_q  <= q_nxt;
            k_q   <= k_int_q;
            ksa_q <= ksa_int_q;
            ksx_q <= ksx_int_q;
            mx3_q <= mx3_int_q;
            err_q <= 1'b0;
          end
        end
        S_DONE: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy         = state_q != S_IDLE;
  assign done         = state_q == S_DONE;
  assign err          = done & err_q;
  assign md           = md_q;
  assign k            = k_q;
  assign k_shft_ah    = ksa_q;
  assign k_shft_ahxmd = ksx_q;
  assign mx3          = mx3_q;

endmodule

// File: tb/tb_barrett_param_gen.sv
// Scoreboard bench for barrett_param_gen at NBITS=16, LOG2POLYDEG=3.
module tb_barrett_param_gen;

  localparam int NB = 16;
  localparam int L2 = 3;

  typedef struct {
    logic [NB:0]   md;
    logic [5:0]    k;
    logic [4:0]    ksa;
    logic [4:0]    ksx;
    logic [NB+1:0] mx3;
    logic          err;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NB-1:0] m = '0;
  logic          busy, done, err;
  logic [NB:0]   md;
  logic [5:0]    k;
  logic [4:0]    k_shft_ah, k_shft_ahxmd;
  logic [NB+1:0] mx3;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  barrett_param_gen #(.NBITS(NB), .LOG2POLYDEG(L2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .m            (m),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .md           (md),
    .k            (k),
    .k_shft_ah    (k_shft_ah),
    .k_shft_ahxmd (k_shft_ahxmd),
    .mx3          (mx3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (err && !done) begin
        errors++;
        $display("FAIL err_without_done: got 1 expected 0 (cycle %0d)", cyc);
      end
      if (done) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency_cycle", 64'(cyc), 64'(e.cyc));
          chk("err", 64'(err), 64'(e.err));
          chk("md", 64'(md), 64'(e.md));
          chk("k", 64'(k), 64'(e.k));
          chk("k_shft_ah", 64'(k_shft_ah), 64'(e.ksa));
          chk("k_shft_ahxmd", 64'(k_shft_ahxmd), 64'(e.ksx));
          chk("mx3", 64'(mx3), 64'(e.mx3));
        end
      end
    end
  end

  // Drive a start at a negedge; lat is edges from the start edge to the done cycle.
  task automatic issue(input logic [NB-1:0] mm, input logic [NB:0] emd, input logic [5:0] ek,
                       input logic [4:0] esa, input logic [4:0] esx, input logic [NB+1:0] emx,
                       input logic eerr, input int lat);
    exp_t e;
    e.md = emd; e.k = ek; e.ksa = esa; e.ksx = esx; e.mx3 = emx; e.err = eerr;
    e.cyc = cyc + lat;
    sb.push_back(e);
    start = 1'b1;
    m = mm;
    @(negedge clk);
    start = 1'b0;
    m = $urandom_range(0, 65535);
    chk("busy_rise", 64'(busy), 64'd1);
  endtask

  task automatic issue_ok(input logic [NB-1:0] mm, input logic [NB:0] emd, input logic [5:0] ek,
                          input logic [NB+1:0] emx);
    issue(mm, emd, ek, 5'(ek / 2 - 1), 5'(ek / 2 + 1), emx, 1'b0, int'(ek) / 2 + 3);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles");
      sb.delete();
    end
    @(negedge clk);
    chk("busy_fall", 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_md", 64'(md), 64'd0);
    chk("rst_k", 64'(k), 64'd0);
    chk("rst_mx3", 64'(mx3), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Hand-computed directed vectors.
    issue_ok(16'd17, 17'd60, 6'd10, 18'd51);                 wait_done();
    repeat (3) @(negedge clk);
    chk("hold_md", 64'(md), 64'd60);
    chk("hold_k", 64'(k), 64'd10);
    issue_ok(16'hFFF1, 17'h1000F, 6'd32, 18'h2FFD3);         wait_done();
    issue_ok(16'd49, 17'd83, 6'd12, 18'd147);                wait_done();
    issue_ok(16'h8001, 17'h1FFFC, 6'd32, 18'h18003);         wait_done();
    issue(16'h0013, '0, '0, '0, '0, '0, 1'b1, 1);            wait_done();
    issue(16'h0001, '0, '0, '0, '0, '0, 1'b1, 1);            wait_done();

    // A start during DIV must be ignored.
    issue_ok(16'd17, 17'd60, 6'd10, 18'd51);
    repeat (3) @(negedge clk);
    start = 1'b1; m = 16'hFFF1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (25) @(negedge clk);

    // Reset in the middle of DIV: no done, everything cleared.
    issue_ok(16'hFFF1, 17'h1000F, 6'd32, 18'h2FFD3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_md", 64'(md), 64'd0);
    chk("midrst_k", 64'(k), 64'd0);
    chk("midrst_mx3", 64'(mx3), 64'd0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    issue_ok(16'd17, 17'd60, 6'd10, 18'd51);                 wait_done();

    // Strided sweep of valid moduli against floor(2^(2n)/m).
    for (int mm = 17; mm < 65536; mm += 112) begin
      int n;
      logic [63:0] ref_md;
      n = 0;
      for (int b = 0; b < NB; b++) if (mm[b]) n = b + 1;
      ref_md = (64'd1 << (2 * n)) / 64'(mm);
      issue(NB'(mm), (NB+1)'(ref_md), 6'(2 * n), 5'(n - 1), 5'(n + 1),
            (NB+2)'(3 * mm), 1'b0, n + 3);
      wait_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
